// File: rtl/pass_cam_if.sv
// rtl/pass_cam_if.sv - FSM-to-CAM command/result bundle for the password store
interface pass_cam_if #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 4
);
    logic              cam_start;
    logic              cam_write_en;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic              clear;
    logic              match;
    logic [ADDR_W-1:0] match_addr;
    logic              search_done;
    logic              busy;
    logic [ADDR_W-1:0] max_add;
    logic              empty;

    modport master (
        output cam_start, cam_write_en, address, data_in, clear,
        input  match, match_addr, search_done, busy, max_add, empty
    );

    modport slave (
        input  cam_start, cam_write_en, address, data_in, clear,
        output match, match_addr, search_done, busy, max_add, empty
    );
endinterface

// File: rtl/pass_cam.sv
// rtl/pass_cam.sv - sequential-search password CAM with valid bits and max-address tracking
module pass_cam #(
    parameter int DATA_W = 128,
    parameter int ADDR_W = 4
) (
    input  logic        clk,
    input  logic        rst,
    pass_cam_if.slave   bus
);
    localparam int DEPTH = 1 << ADDR_W;

    typedef enum logic {
        IDLE,
        SEARCH
    } state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  valid_q;
    logic [DATA_W-1:0] key_q;
    logic [ADDR_W-1:0] idx_q;
    logic [ADDR_W-1:0] max_add_q;
    logic [ADDR_W-1:0] match_addr_q;
    logic              match_q;
    logic              done_q;
    logic              busy_q;
    logic              empty_q;
    logic              empty_pend_q;

    logic              do_clear;
    logic              do_write;
    logic              do_start;
    logic              do_start_empty;
    logic              hit;
    logic              miss_end;
    logic              advance;
    logic              hit_now;
    logic [ADDR_W-1:0] wr_max;

    // Invalid holes never hit, so a stale word left by clear cannot match.
    assign hit_now = valid_q[idx_q] && (mem[idx_q] == key_q);

    assign wr_max = empty_q ? bus.address
                  : ((bus.address > max_add_q) ? bus.address : max_add_q);

    always_comb begin
        state_d        = state_q;
        do_clear       = 1'b0;
        do_write       = 1'b0;
        do_start       = 1'b0;
        do_start_empty = 1'b0;
        hit            = 1'b0;
        miss_end       = 1'b0;
        advance        = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.clear) begin
                    do_clear = 1'b1;
                end else if (bus.cam_write_en) begin
                    do_write = 1'b1;
                end else if (bus.cam_start) begin
                    if (empty_q) begin
                        do_start_empty = 1'b1;
                    end else begin
                        do_start = 1'b1;
                        state_d  = SEARCH;
                    end
                end
            end
            SEARCH: begin
                if (hit_now) begin
                    hit     = 1'b1;
                    state_d = IDLE;
                end else if (idx_q == max_add_q) begin
                    miss_end = 1'b1;
                    state_d  = IDLE;
                end else begin
                    advance = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q      <= IDLE;
            valid_q      <= '0;
            key_q        <= '0;
            idx_q        <= '0;
            max_add_q    <= '0;
            match_addr_q <= '0;
            match_q      <= 1'b0;
            done_q       <= 1'b0;
            busy_q       <= 1'b0;
            empty_q      <= 1'b1;
            empty_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            // An empty-store search reports a miss one edge after it was accepted.
            done_q       <= empty_pend_q;
            empty_pend_q <= 1'b0;

            if (do_clear) begin
                valid_q   <= '0;
                max_add_q <= '0;
                empty_q   <= 1'b1;
                match_q   <= 1'b0;
            end

            if (do_write) begin
                valid_q[bus.address] <= 1'b1;
                empty_q              <= 1'b0;
                max_add_q            <= wr_max;
                match_q              <= 1'b0;
            end

            if (do_start_empty) begin
                empty_pend_q <= 1'b1;
                match_q      <= 1'b0;
                match_addr_q <= '0;
            end

            if (do_start) begin
                key_q   <= bus.data_in;
                idx_q   <= '0;
                busy_q  <= 1'b1;
                match_q <= 1'b0;
            end

            if (hit) begin
                match_q      <= 1'b1;
                match_addr_q <= idx_q;
                done_q       <= 1'b1;
                busy_q       <= 1'b0;
            end

            if (miss_end) begin
                match_q      <= 1'b0;
                match_addr_q <= '0;
                done_q       <= 1'b1;
                busy_q       <= 1'b0;
            end

            if (advance) begin
                idx_q <= idx_q + 1'b1;
            end
        end
    end

    // Storage carries no reset; valid_q alone decides what is visible.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem[bus.address] <= bus.data_in;
        end
    end

    assign bus.match       = match_q;
    assign bus.match_addr  = match_addr_q;
    assign bus.search_done = done_q;
    assign bus.busy        = busy_q;
    assign bus.max_add     = max_add_q;
    assign bus.empty       = empty_q;
endmodule

// File: tb/tb_pass_cam.sv
// tb/tb_pass_cam.sv - table-driven and randomized checks of pass_cam against a reference model
module tb_pass_cam;
    logic clk;
    logic rst;
    pass_cam_if bus ();

    pass_cam u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;

    logic [127:0] m_mem [16];
    bit           m_valid [16];
    int           m_max;
    bit           m_empty;
    logic [127:0] pool [8];

    typedef struct {
        int op;
        int addr;
        int key_sel;
        bit exp_match;
        int exp_addr;
        int exp_lat;
    } vec_t;

    vec_t vecs [$];

    localparam int OP_WR  = 0;
    localparam int OP_SR  = 1;
    localparam int OP_CLR = 2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_max   = 0;
        m_empty = 1'b1;
    endtask

    task automatic ref_search(input logic [127:0] key, output bit m, output int a, output int lat);
        m   = 1'b0;
        a   = 0;
        lat = m_empty ? 1 : m_max + 1;
        if (!m_empty) begin
            for (int i = 0; i <= m_max; i++) begin
                if (m_valid[i] && m_mem[i] == key) begin
                    m   = 1'b1;
                    a   = i;
                    lat = i + 1;
                    break;
                end
            end
        end
    endtask

    task automatic do_write(input int a, input logic [127:0] d);
        bus.cam_write_en = 1'b1;
        bus.address      = 4'(a);
        bus.data_in      = d;
        tick();
        bus.cam_write_en = 1'b0;
        m_mem[a]   = d;
        m_valid[a] = 1'b1;
        m_max      = m_empty ? a : (a > m_max ? a : m_max);
        m_empty    = 1'b0;
        chk("wr_max_add", 128'(bus.max_add), 128'(m_max));
        chk("wr_empty", 128'(bus.empty), 128'(0));
        chk("wr_match", 128'(bus.match), 128'(0));
    endtask

    task automatic do_clear();
        bus.clear = 1'b1;
        tick();
        bus.clear = 1'b0;
        model_reset();
        chk("clr_empty", 128'(bus.empty), 128'(1));
        chk("clr_max_add", 128'(bus.max_add), 128'(0));
        chk("clr_match", 128'(bus.match), 128'(0));
    endtask

    task automatic run_search(input logic [127:0] key, input bit em, input int ea, input int elat,
                              input string tag);
        int n;
        bit busy_bad;
        bit seen;
        bit exp_busy;
        exp_busy = !m_empty;
        bus.cam_start = 1'b1;
        bus.data_in   = key;
        tick();
        bus.cam_start = 1'b0;
        bus.data_in   = rnd128();
        n = 0;
        busy_bad = 1'b0;
        seen = 1'b0;
        while (n < 40) begin
            if (bus.busy !== exp_busy || bus.search_done !== 1'b0) busy_bad = 1'b1;
            tick();
            n++;
            if (bus.search_done === 1'b1) begin
                seen = 1'b1;
                break;
            end
        end
        chk({tag, "_timeout"}, 128'(seen), 128'(1));
        chk({tag, "_busy_during"}, 128'(busy_bad), 128'(0));
        chk({tag, "_latency"}, 128'(n), 128'(elat));
        chk({tag, "_match"}, 128'(bus.match), 128'(em));
        chk({tag, "_match_addr"}, 128'(bus.match_addr), 128'(ea));
        chk({tag, "_busy_after"}, 128'(bus.busy), 128'(0));
        tick();
        chk({tag, "_done_one_cycle"}, 128'(bus.search_done), 128'(0));
        chk({tag, "_match_held"}, 128'(bus.match), 128'(em));
    endtask

    task automatic model_search(input logic [127:0] key, input string tag);
        bit m;
        int a;
        int lat;
        ref_search(key, m, a, lat);
        run_search(key, m, a, lat, tag);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        bus.cam_start    = 1'b0;
        bus.cam_write_en = 1'b0;
        bus.clear        = 1'b0;
        bus.address      = '0;
        bus.data_in      = '0;
        for (int i = 0; i < 8; i++) pool[i] = rnd128();
        model_reset();
        tick();
        tick();
        chk("rst_match", 128'(bus.match), 128'(0));
        chk("rst_match_addr", 128'(bus.match_addr), 128'(0));
        chk("rst_done", 128'(bus.search_done), 128'(0));
        chk("rst_busy", 128'(bus.busy), 128'(0));
        chk("rst_max_add", 128'(bus.max_add), 128'(0));
        chk("rst_empty", 128'(bus.empty), 128'(1));
        rst = 1'b1;
        tick();

        run_search({16{8'hAA}}, 1'b0, 0, 1, "empty_aa");

        vecs.push_back('{OP_CLR, 0, 0, 0, 0, 0});
        vecs.push_back('{OP_WR,  0, 0, 0, 0, 0});
        vecs.push_back('{OP_WR,  1, 1, 0, 0, 0});
        vecs.push_back('{OP_WR,  2, 2, 0, 0, 0});
        vecs.push_back('{OP_SR,  0, 2, 1, 2, 3});
        vecs.push_back('{OP_SR,  0, 7, 0, 0, 3});
        vecs.push_back('{OP_SR,  0, 0, 1, 0, 1});
        vecs.push_back('{OP_CLR, 0, 0, 0, 0, 0});
        vecs.push_back('{OP_SR,  0, 0, 0, 0, 1});
        vecs.push_back('{OP_WR,  5, 5, 0, 0, 0});
        vecs.push_back('{OP_SR,  0, 5, 1, 5, 6});
        vecs.push_back('{OP_SR,  0, 1, 0, 0, 6});
        vecs.push_back('{OP_WR,  9, 5, 0, 0, 0});
        vecs.push_back('{OP_SR,  0, 5, 1, 5, 6});
        vecs.push_back('{OP_SR,  0, 3, 0, 0, 10});
        vecs.push_back('{OP_WR,  2, 3, 0, 0, 0});
        vecs.push_back('{OP_SR,  0, 3, 1, 2, 3});
        vecs.push_back('{OP_WR, 15, 6, 0, 0, 0});
        vecs.push_back('{OP_SR,  0, 6, 1, 15, 16});
        vecs.push_back('{OP_SR,  0, 7, 0, 0, 16});
        foreach (vecs[i]) begin
            case (vecs[i].op)
                OP_WR:  do_write(vecs[i].addr, pool[vecs[i].key_sel]);
                OP_CLR: do_clear();
                default: run_search(pool[vecs[i].key_sel], vecs[i].exp_match, vecs[i].exp_addr,
                                    vecs[i].exp_lat, $sformatf("vec%0d", i));
            endcase
        end

        // Commands issued while searching must be dropped, not queued.
        begin
            int n;
            do_clear();
            do_write(0, pool[0]);
            do_write(1, pool[1]);
            do_write(2, pool[2]);
            bus.cam_start = 1'b1;
            bus.data_in   = pool[2];
            tick();
            bus.cam_start    = 1'b0;
            bus.cam_write_en = 1'b1;
            bus.address      = 4'd0;
            bus.data_in      = pool[7];
            bus.clear        = 1'b1;
            n = 0;
            while (n < 40 && bus.search_done !== 1'b1) begin
                tick();
                n++;
            end
            bus.cam_write_en = 1'b0;
            bus.clear        = 1'b0;
            chk("ign_latency", 128'(n), 128'(3));
            chk("ign_match", 128'(bus.match), 128'(1));
            chk("ign_match_addr", 128'(bus.match_addr), 128'(2));
            chk("ign_max_add", 128'(bus.max_add), 128'(2));
            chk("ign_empty", 128'(bus.empty), 128'(0));
            tick();
            model_search(pool[0], "ign_k0");
        end

        // Write beats start; the start is dropped entirely.
        begin
            bit stray;
            bus.cam_write_en = 1'b1;
            bus.cam_start    = 1'b1;
            bus.address      = 4'd3;
            bus.data_in      = pool[3];
            tick();
            bus.cam_write_en = 1'b0;
            bus.cam_start    = 1'b0;
            m_mem[3] = pool[3];
            m_valid[3] = 1'b1;
            m_max = 3;
            chk("ws_match", 128'(bus.match), 128'(0));
            chk("ws_busy", 128'(bus.busy), 128'(0));
            chk("ws_max_add", 128'(bus.max_add), 128'(3));
            stray = 1'b0;
            for (int i = 0; i < 5; i++) begin
                tick();
                if (bus.search_done !== 1'b0 || bus.busy !== 1'b0) stray = 1'b1;
            end
            chk("ws_no_search", 128'(stray), 128'(0));
            model_search(pool[3], "ws_k3");
        end

        // Reset in the middle of a search aborts it silently.
        begin
            do_clear();
            do_write(0, pool[0]);
            do_write(1, pool[1]);
            do_write(2, pool[2]);
            bus.cam_start = 1'b1;
            bus.data_in   = pool[2];
            tick();
            bus.cam_start = 1'b0;
            tick();
            rst = 1'b0;
            tick();
            chk("rmid_match", 128'(bus.match), 128'(0));
            chk("rmid_match_addr", 128'(bus.match_addr), 128'(0));
            chk("rmid_done", 128'(bus.search_done), 128'(0));
            chk("rmid_busy", 128'(bus.busy), 128'(0));
            chk("rmid_max_add", 128'(bus.max_add), 128'(0));
            chk("rmid_empty", 128'(bus.empty), 128'(1));
            rst = 1'b1;
            tick();
            chk("rmid_no_done", 128'(bus.search_done), 128'(0));
            model_reset();
            model_search(pool[2], "rmid_after");
        end

        for (int t = 0; t < 150; t++) begin
            int r;
            r = int'($urandom_range(0, 19));
            if (r == 0) begin
                do_clear();
            end else if (r < 10) begin
                do_write(int'($urandom_range(0, 15)), pool[$urandom_range(0, 5)]);
            end else begin
                model_search(pool[$urandom_range(0, 7)], $sformatf("rnd%0d", t));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/pass_cam.md
Name: pass_cam

Overview:
- Password content-addressable store for the Pass-Keeper datapath, directly downstream of the control FSM.
- Writes and searches are driven by the FSM's cam_start, cam_write_en and address_out. Results go back to the FSM on match and max_add.
- Search is sequential: one entry compared per clock. The block holds valid bits and the highest-written-address tracker.

Parameters:
DATA_W, 128, width of a stored password/key word
ADDR_W, 4, address width; DEPTH = 2**ADDR_W entries

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous, active-low reset; sampled on the clk rising edge
cam_start  input  1  search request; sampled only in IDLE
cam_write_en  input  1  write request; sampled only in IDLE
address  input  ADDR_W  write address, from FSM address_out
data_in  input  DATA_W  write data, or search key (captured at start)
clear  input  1  invalidate all entries; honoured only in IDLE
match  output  1  last search hit; registered
match_addr  output  ADDR_W  index of the hit entry; registered
search_done  output  1  one-cycle pulse when a search finishes
busy  output  1  high while in SEARCH
max_add  output  ADDR_W  highest address ever written since reset/clear
empty  output  1  no valid entries

Behaviour:
- Reset (rst=0 at a rising edge):
  - All valid bits cleared; state IDLE.
  - match=0, match_addr=0, search_done=0, busy=0, max_add=0, empty=1.
  - Storage contents are don't-care.
  - Reset mid-search aborts the search with no search_done.
- States: IDLE, SEARCH.
- IDLE priority, highest first: clear > cam_write_en > cam_start.
  - clear: all valid=0, max_add=0, empty=1, match=0. Write and start in the same cycle are dropped.
  - write:
    - mem[address]=data_in, valid[address]=1, empty=0.
    - max_add = (empty ? address : max(max_add, address)).
    - match cleared to 0.
    - A simultaneous cam_start is dropped; the FSM must re-issue it.
  - start:
    - key<=data_in, idx<=0, busy<=1, match<=0, go to SEARCH.
    - If empty=1: stay IDLE, pulse search_done with match=0 on the next edge (latency 1).
- SEARCH, in each cycle:
  - Compare key with mem[idx], qualified by valid[idx]. Invalid holes are skipped as misses.
  - Hit: match<=1, match_addr<=idx, search_done<=1, busy<=0, go to IDLE.
  - Miss with idx==max_add: match<=0, match_addr<=0, search_done<=1, busy<=0, go to IDLE.
  - Miss otherwise: idx<=idx+1.
  - Lowest matching index wins on duplicates.
- Latency: with start sampled at edge E0, a hit at entry k reports at edge E(k+1); a miss reports at edge E(max_add+1). Maximum is DEPTH cycles.
- During SEARCH, cam_start, cam_write_en and clear are ignored (not queued). data_in may change after start.
- search_done is high for exactly one cycle. match and match_addr hold until the next start, write or clear.
- idx never wraps: termination at max_add is guaranteed. Overwriting an existing address does not change max_add unless that address is larger.
- Output max_add is consumed by the FSM's address comparison. With empty=1, max_add reads 0.

Test Plan:
- Reset then start with key 0xAA..AA -> search_done pulse 1 cycle later, match=0, empty=1, max_add=0, busy never high.
- Write addr 0,1,2 with K0,K1,K2; start with K2 -> busy for 3 cycles, search_done and match=1 at E3, match_addr=2, max_add=2.
- Same contents, start with unknown key -> miss at E3, match=0; search_done high exactly one cycle.
- Write addr 5 only (holes 0-4), then search for its key -> max_add=5, hit at E6, match_addr=5.
- Assert cam_write_en at addr 0 and clear during SEARCH -> both ignored, result unchanged. Then assert write and start together in IDLE -> write performed, no search begins, match=0.
- rst low at cycle 2 of a 3-entry search -> no search_done; all outputs at reset values next cycle. A subsequent search on the now-empty CAM misses in 1 cycle.
